// File: rtl/subword_store_unit.sv
// Store-side data path for sb/sh/sw: narrows the rt value to the store width,
// merges it into the addressed lanes of the memory word, and writes it back.
module subword_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              misalign
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [2:0]        state;
   logic [2:0]        next_state;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       data_lo;
   logic [1:0]        size_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merged;
   logic              bad_req;
   logic              accept;

   assign accept = (state == S_IDLE) && req_valid;

   always_comb begin
      bad_req = 1'b0;
      case (req_size)
         SZ_BYTE: bad_req = 1'b0;
         SZ_HALF: bad_req = req_addr[0];
         SZ_WORD: bad_req = (req_addr[1:0] != 2'b00);
         default: bad_req = 1'b1;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (bad_req)
                  next_state = S_ERR;
               else if (req_size == SZ_WORD)
                  next_state = S_WRITE;
               else
                  next_state = S_READ;
            end
         end
         S_READ:  next_state = S_MERGE;
         S_MERGE: next_state = S_WRITE;
         S_WRITE: next_state = S_IDLE;
         S_ERR:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Only the addressed lane(s) take the new data; the rest come from memory.
   always_comb begin
      merged = mem_rdata;
      if (size_q == SZ_BYTE) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = data_lo[7:0];
            2'd1:    merged[15:8]  = data_lo[7:0];
            2'd2:    merged[23:16] = data_lo[7:0];
            default: merged[31:24] = data_lo[7:0];
         endcase
      end else begin
         if (addr_q[1])
            merged[31:16] = data_lo;
         else
            merged[15:0]  = data_lo;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         data_lo <= '0;
         size_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= req_addr;
         data_lo <= req_data[15:0];
         size_q  <= req_size;
         if (req_size == SZ_WORD)
            wdata_q <= req_data;
      end else if (state == S_MERGE) begin
         wdata_q <= merged;
      end
   end

   assign req_ready = (state == S_IDLE);
   assign mem_rd_en = (state == S_READ);
   assign mem_wr_en = (state == S_WRITE);
   assign done      = (state == S_WRITE) || (state == S_ERR);
   assign misalign  = (state == S_ERR);
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_subword_store_unit.sv
// Directed bench for subword_store_unit with a small synchronous word memory.
module tb_subword_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;
   logic        done;
   logic        misalign;

   logic [31:0] mem [0:15];
   int          wr_count;
   int          rd_count;
   int          done_count;
   logic        both_seen;

   int          checks;
   int          passes;

   logic        obs_ready [1:5];
   logic        obs_rd    [1:5];
   logic        obs_wr    [1:5];
   logic        obs_done  [1:5];
   logic        obs_mis   [1:5];
   logic [31:0] obs_addr  [1:5];
   logic [31:0] obs_wdata [1:5];

   subword_store_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .done      (done),
      .misalign  (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous word memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rdata <= mem[mem_addr[5:2]];
         rd_count  <= rd_count + 1;
      end
      if (mem_wr_en) begin
         mem[mem_addr[5:2]] <= mem_wdata;
         wr_count <= wr_count + 1;
      end
      if (done)
         done_count <= done_count + 1;
      if (mem_rd_en && mem_wr_en)
         both_seen <= 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      else
         passes++;
   endtask

   task automatic capture(input int i);
      obs_ready[i] = req_ready;
      obs_rd[i]    = mem_rd_en;
      obs_wr[i]    = mem_wr_en;
      obs_done[i]  = done;
      obs_mis[i]   = misalign;
      obs_addr[i]  = mem_addr;
      obs_wdata[i] = mem_wdata;
   endtask

   // Presents one request in cycle T and records cycles T+1..T+4.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      @(negedge clk);
      checkOutput("ready_before_req", {31'b0, req_ready}, 32'd1);
      req_addr  = addr;
      req_data  = data;
      req_size  = size;
      req_valid = 1'b1;
      @(negedge clk);
      capture(1);
      req_valid = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         capture(i);
      end
   endtask

   logic [31:0] byte_exp [0:3];
   int          wr_base;
   int          rd_base;
   int          done_base;

   initial begin
      checks     = 0;
      passes     = 0;
      wr_count   = 0;
      rd_count   = 0;
      done_count = 0;
      both_seen  = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_size  = '0;
      byte_exp[0] = 32'h1122_33AB;
      byte_exp[1] = 32'h1122_AB44;
      byte_exp[2] = 32'h11AB_3344;
      byte_exp[3] = 32'hAB22_3344;

      repeat (2) @(negedge clk);
      checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
      checkOutput("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
      checkOutput("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;

      // Aligned word store
      rd_base = rd_count;
      applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
      checkOutput("sw_wr_t1", {31'b0, obs_wr[1]}, 32'd1);
      checkOutput("sw_done_t1", {31'b0, obs_done[1]}, 32'd1);
      checkOutput("sw_mis_t1", {31'b0, obs_mis[1]}, 32'd0);
      checkOutput("sw_addr_t1", obs_addr[1], 32'h10);
      checkOutput("sw_wdata_t1", obs_wdata[1], 32'hDEAD_BEEF);
      checkOutput("sw_ready_t1", {31'b0, obs_ready[1]}, 32'd0);
      checkOutput("sw_ready_t2", {31'b0, obs_ready[2]}, 32'd1);
      checkOutput("sw_wr_t2", {31'b0, obs_wr[2]}, 32'd0);
      checkOutput("sw_no_read", rd_count - rd_base, 32'd0);
      checkOutput("sw_mem", mem[4], 32'hDEAD_BEEF);

      // Byte store into each lane of 0x1122_3344
      for (int k = 0; k < 4; k++) begin
         mem[8] = 32'h1122_3344;
         applyStimulus(32'h20 + k, 32'hFFFF_FFAB, 2'b00);
         checkOutput($sformatf("sb%0d_rd_t1", k), {31'b0, obs_rd[1]}, 32'd1);
         checkOutput($sformatf("sb%0d_addr_t1", k), obs_addr[1], 32'h20);
         checkOutput($sformatf("sb%0d_wr_t2", k), {31'b0, obs_wr[2]}, 32'd0);
         checkOutput($sformatf("sb%0d_wr_t3", k), {31'b0, obs_wr[3]}, 32'd1);
         checkOutput($sformatf("sb%0d_done_t3", k), {31'b0, obs_done[3]}, 32'd1);
         checkOutput($sformatf("sb%0d_addr_t3", k), obs_addr[3], 32'h20);
         checkOutput($sformatf("sb%0d_wdata", k), obs_wdata[3], byte_exp[k]);
         checkOutput($sformatf("sb%0d_ready_t4", k), {31'b0, obs_ready[4]}, 32'd1);
         checkOutput($sformatf("sb%0d_mem", k), mem[8], byte_exp[k]);
      end

      // Halfword stores
      mem[0] = 32'hAAAA_BBBB;
      applyStimulus(32'h0000_0002, 32'h0000_1234, 2'b01);
      checkOutput("sh_hi_rd_t1", {31'b0, obs_rd[1]}, 32'd1);
      checkOutput("sh_hi_wr_t3", {31'b0, obs_wr[3]}, 32'd1);
      checkOutput("sh_hi_wdata", obs_wdata[3], 32'h1234_BBBB);
      mem[0] = 32'hAAAA_BBBB;
      applyStimulus(32'h0000_0000, 32'h0000_1234, 2'b01);
      checkOutput("sh_lo_wdata", obs_wdata[3], 32'hAAAA_1234);
      checkOutput("sh_lo_mem", mem[0], 32'hAAAA_1234);

      // Misaligned and reserved-size requests
      begin
         logic [31:0] mis_addr [0:2];
         logic [1:0]  mis_size [0:2];
         mis_addr[0] = 32'h3; mis_size[0] = 2'b01;
         mis_addr[1] = 32'h6; mis_size[1] = 2'b10;
         mis_addr[2] = 32'h0; mis_size[2] = 2'b11;
         for (int k = 0; k < 3; k++) begin
            wr_base = wr_count;
            rd_base = rd_count;
            applyStimulus(mis_addr[k], 32'h5555_5555, mis_size[k]);
            checkOutput($sformatf("mis%0d_done_t1", k), {31'b0, obs_done[1]}, 32'd1);
            checkOutput($sformatf("mis%0d_flag_t1", k), {31'b0, obs_mis[1]}, 32'd1);
            checkOutput($sformatf("mis%0d_strobes_t1", k), {30'b0, obs_rd[1], obs_wr[1]}, 32'd0);
            checkOutput($sformatf("mis%0d_ready_t2", k), {31'b0, obs_ready[2]}, 32'd1);
            checkOutput($sformatf("mis%0d_done_t2", k), {31'b0, obs_done[2]}, 32'd0);
            checkOutput($sformatf("mis%0d_no_access", k), (wr_count - wr_base) + (rd_count - rd_base), 32'd0);
         end
      end

      // Reset dropped in the MERGE cycle of a byte store
      mem[8]    = 32'h1122_3344;
      wr_base   = wr_count;
      done_base = done_count;
      @(negedge clk);
      req_addr  = 32'h21;
      req_data  = 32'h0000_0055;
      req_size  = 2'b00;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("rstmid_rd_t1", {31'b0, mem_rd_en}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_ready", {31'b0, req_ready}, 32'd1);
      checkOutput("rstmid_strobes", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
      checkOutput("rstmid_done", {30'b0, done, misalign}, 32'd0);
      checkOutput("rstmid_mem_addr", mem_addr, 32'd0);
      checkOutput("rstmid_mem_wdata", mem_wdata, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("rstmid_no_write", wr_count - wr_base, 32'd0);
      checkOutput("rstmid_no_done", done_count - done_base, 32'd0);
      checkOutput("rstmid_mem_kept", mem[8], 32'h1122_3344);
      rst_n = 1'b1;
      applyStimulus(32'h0000_0010, 32'h0123_4567, 2'b10);
      checkOutput("postrst_wr_t1", {31'b0, obs_wr[1]}, 32'd1);
      checkOutput("postrst_wdata", obs_wdata[1], 32'h0123_4567);
      checkOutput("postrst_mem", mem[4], 32'h0123_4567);

      // req_valid held high with changing inputs during a byte store
      mem[9]  = 32'h9988_7766;
      mem[10] = 32'h0;
      mem[11] = 32'h0;
      wr_base = wr_count;
      @(negedge clk);
      req_addr  = 32'h24;
      req_data  = 32'hFFFF_FF11;
      req_size  = 2'b00;
      req_valid = 1'b1;
      @(negedge clk);
      checkOutput("hold_ready_t1", {31'b0, req_ready}, 32'd0);
      checkOutput("hold_rd_t1", {31'b0, mem_rd_en}, 32'd1);
      req_addr = 32'h2C;
      req_data = 32'h0BAD_0001;
      req_size = 2'b10;
      @(negedge clk);
      checkOutput("hold_ready_t2", {31'b0, req_ready}, 32'd0);
      req_data = 32'h0BAD_0002;
      @(negedge clk);
      checkOutput("hold_ready_t3", {31'b0, req_ready}, 32'd0);
      checkOutput("hold_wr_t3", {31'b0, mem_wr_en}, 32'd1);
      checkOutput("hold_wdata_t3", mem_wdata, 32'h9988_7711);
      req_addr = 32'h28;
      req_data = 32'hCAFE_F00D;
      @(negedge clk);
      checkOutput("hold_ready_t4", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      checkOutput("hold_wr_t5", {31'b0, mem_wr_en}, 32'd1);
      checkOutput("hold_addr_t5", mem_addr, 32'h28);
      checkOutput("hold_wdata_t5", mem_wdata, 32'hCAFE_F00D);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("hold_mem_byte", mem[9], 32'h9988_7711);
      checkOutput("hold_mem_word", mem[10], 32'hCAFE_F00D);
      checkOutput("hold_mem_ignored", mem[11], 32'h0);
      checkOutput("hold_write_count", wr_count - wr_base, 32'd2);

      checkOutput("no_dual_strobe", {31'b0, both_seen}, 32'd0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
